uart_reset_sequencer: RTL
=========================

# uart_reset_sequencer

Synthesizable reset controller for the UART responder design. It takes the single asynchronous active-low board reset and synchronizes its deassertion. It then releases N downstream reset domains in a fixed order with programmed gaps, for example clock/baud generator first, then UART core, then responder logic. It also supports a software-initiated reset through a req/ack handshake.

## Interface
Parameters:
- `N_DOMAINS`, 3: number of sequenced reset outputs; must be ≥1.
- `SYNC_STAGES`, 2: deassertion synchronizer depth; must be ≥2.
- `HOLD_CYCLES`, 100: cycles all domains stay in reset after the synchronized deassertion; must be ≥1.
- `GAP_CYCLES`, 16: cycles between successive domain releases; must be ≥1.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low.
- `soft_req` in 1: level request for a full re-sequence.
- `soft_ack` out 1: one-cycle pulse acknowledging `soft_req`.
- `domain_rst_n` out N_DOMAINS: per-domain active-low reset; bit 0 is released first.
- `ready` out 1: high when all domains are released.

## Operation
- Outputs while `reset`=0: `domain_rst_n`=all 0, `ready`=0, `soft_ack`=0. All asserted asynchronously, in the same instant as `reset` falls.
- Synchronizer: `SYNC_STAGES` flops, all cleared asynchronously by `reset`; `1` is shifted in. The output `rst_sync_n` rises on the SYNC_STAGES-th rising edge after `reset` deasserts.
- FSM states: SYNC, HOLD, RELEASE, RUN, SOFT.
- SYNC: the reset state.
  - Wait for `rst_sync_n`=1.
  - Then go to HOLD and load the counter with HOLD_CYCLES-1.
- HOLD: decrement the counter.
  - At 0, set `domain_rst_n[0]`=1.
  - Load GAP_CYCLES-1 and set index=1.
  - Go to RELEASE, or go directly to RUN if N_DOMAINS=1.
- RELEASE: decrement the counter.
  - At 0, set `domain_rst_n[index]`=1.
  - If index=N_DOMAINS-1, go to RUN; otherwise increment index and reload GAP_CYCLES-1.
- RUN: `ready`=1, registered on state entry.
  - If `soft_req`=1, go to SOFT.
- SOFT: for one cycle `domain_rst_n`=all 0, `ready`=0 and `soft_ack`=1.
  - Then go to HOLD with the counter at HOLD_CYCLES-1.
- Once a domain is released, it stays released until `reset` falls or SOFT is entered. Released bits are monotonic within a sequence.
- `soft_req` outside RUN is ignored, not latched.
  - The requester holds `soft_req` until it sees `soft_ack`.
  - If `soft_req` is still 1 when RUN is next reached, a further sequence starts. Level semantics are intended.
- Counter width: `$clog2(max(HOLD_CYCLES,GAP_CYCLES))`, minimum 1. Index width: `$clog2(N_DOMAINS)`, minimum 1. No wrap: the counter only decrements to 0 and is then reloaded.
- `reset` falling mid-sequence or mid-SOFT aborts immediately to SYNC with all outputs at reset values. The sequence restarts from the top.
- Elaboration-time `$fatal` on illegal parameter values.

## Timing
- S is the edge on which `rst_sync_n` is first sampled 1, i.e. the edge on which the FSM leaves SYNC.
- `domain_rst_n[0]` rises at S+HOLD_CYCLES.
- `domain_rst_n[k]` rises at S+HOLD_CYCLES+k·GAP_CYCLES.
- `ready` rises one edge after the last domain release.
- Soft reset: `soft_req` sampled 1 in RUN at edge T.
  - At T+1: `soft_ack`=1, `domain_rst_n`=0, `ready`=0.
  - Domain 0 releases at T+1+HOLD_CYCLES; later domains follow the same spacing as above.
- All outputs are registered; there are no combinational paths from inputs.

## Structure
- Package `uart_rst_seq_pkg`: FSM state enum `rst_seq_state_e` and the width helper function.
- Sub-module `uart_rst_sync`: parameterized async-assert/sync-deassert synchronizer, reusable by other blocks.
- Top level: FSM, shared down-counter and domain index register.

## Test plan
- Power-on with defaults, `reset` low for 5 cycles then high → domain bits rise at S+100, S+116, S+132; `ready` rises at S+133.
- `soft_req` pulsed high in RUN until ack → single-cycle `soft_ack`, all `domain_rst_n`=0 on the next edge, then the full 100/16/16 release pattern; `ready` returns at T+134.
- `reset` driven low at S+110 (domain 0 released, domain 1 not yet) → all outputs 0 immediately and asynchronously, mid-clock; after release the sequence restarts from SYNC with the original timing.
- `soft_req` high during HOLD and dropped before RUN → no `soft_ack`, no extra sequence; held high through RUN → exactly one ack after RUN is reached.
- Parameter sweep N_DOMAINS=1, HOLD_CYCLES=1, GAP_CYCLES=1 → `domain_rst_n[0]` at S+1, `ready` at S+2. N_DOMAINS=4, GAP_CYCLES=3 → releases spaced 3 edges apart.

Source files
------------

// File: rtl/uart_rst_seq_pkg.sv
// Shared types and width helpers for the UART reset sequencer.
// Holds the sequencer state enum and the counter/index width rules.
package uart_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_SOFT
    } rst_seq_state_e;

    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    // The counter only ever holds a "cycles - 1" load value, so clog2 of the larger span suffices.
    function automatic int cnt_width(input int holdCycles, input int gapCycles);
        return clog2_min1((holdCycles > gapCycles) ? holdCycles : gapCycles);
    endfunction

endpackage

// File: rtl/uart_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer, reusable by any block.
// Output rises on the STAGES-th rising clock edge after reset deasserts.
module uart_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic rst_sync_n
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "uart_rst_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/uart_reset_sequencer.sv
// Reset sequencer: synchronizes board reset, then releases N reset domains in order
// with programmed hold/gap spacing, and supports a soft re-sequence via req/ack.
module uart_reset_sequencer
    import uart_rst_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 100,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 soft_req,
    output logic                 soft_ack,
    output logic [N_DOMAINS-1:0] domain_rst_n,
    output logic                 ready
);

    if (N_DOMAINS < 1) begin : g_bad_n
        $fatal(1, "uart_reset_sequencer: N_DOMAINS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "uart_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "uart_reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $fatal(1, "uart_reset_sequencer: GAP_CYCLES must be >= 1");
    end

    localparam int CntW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IdxW = clog2_min1(N_DOMAINS);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_DOMAINS - 1);

    logic rst_sync_n;

    uart_rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clock     (clock),
        .reset     (reset),
        .rst_sync_n(rst_sync_n)
    );

    rst_seq_state_e       state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 ready_q, ready_d;
    logic                 ack_q, ack_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    // ready and ack are next-state decodes so every output leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ready_d = 1'b0;
        ack_d   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (rst_sync_n) begin
                    state_d = ST_HOLD;
                    cnt_d   = HoldLoad;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    dom_d[0] = 1'b1;
                    cnt_d    = GapLoad;
                    idx_d    = IdxW'(1);
                    state_d  = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    for (int k = 0; k < N_DOMAINS; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            dom_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = GapLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RUN: begin
                if (soft_req) begin
                    state_d = ST_SOFT;
                    dom_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_SOFT: begin
                state_d = ST_HOLD;
                cnt_d   = HoldLoad;
            end

            default: begin
                state_d = ST_SYNC;
                dom_d   = '0;
            end
        endcase
    end

    assign domain_rst_n = dom_q;
    assign ready        = ready_q;
    assign soft_ack     = ack_q;

endmodule
